// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher: copies the next scanline's sprite row from the object ROM into a
// small line buffer during hblank, then serves the pixel under the beam during active video.
module sprite_line_fetch #(
    parameter int          ROW_BITS    = 1,
    parameter int          COL_BITS    = 1,
    parameter int          XY_BITS     = 10,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_start,
    input  logic [XY_BITS-1:0]  next_y,
    input  logic [XY_BITS-1:0]  spr_x,
    input  logic [XY_BITS-1:0]  spr_y,
    input  logic [XY_BITS-1:0]  pixel_x,
    input  logic                video_on,
    output logic [ROW_BITS-1:0] rom_row,
    output logic [COL_BITS-1:0] rom_col,
    input  logic [11:0]         rom_data,
    output logic                fetch_busy,
    output logic [11:0]         pix_rgb,
    output logic                pix_on
);

    // state   | meaning
    // S_IDLE  | waiting for line_start; display path active
    // S_FETCH | presenting row_lat/cnt to the ROM, one column per cycle
    // S_DRAIN | writing the last column returned by the ROM
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    localparam int SPR_W = 2 ** COL_BITS;
    localparam int SPR_H = 2 ** ROW_BITS;
    localparam logic [XY_BITS-1:0]  SPR_W_XY = XY_BITS'(SPR_W);
    localparam logic [XY_BITS-1:0]  SPR_H_XY = XY_BITS'(SPR_H);
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(SPR_W - 1);

    state_t state, state_nx;

    logic [COL_BITS-1:0] cnt, cnt_d, col_hold;
    logic [ROW_BITS-1:0] row_lat, row_hold;
    logic [XY_BITS-1:0]  x_lat, dy, dx;
    logic                line_valid, wr_valid;
    logic                start_ok, hit;
    logic [11:0]         lbuf_px;
    logic [11:0]         lbuf [SPR_W];

    assign dy       = next_y - spr_y;
    assign start_ok = (state == S_IDLE) && line_start && (dy < SPR_H_XY);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_ok) state_nx = S_FETCH;
            S_FETCH: if (cnt == COL_LAST) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign fetch_busy = (state != S_IDLE);
    // Outside FETCH the ROM address holds the last column presented.
    assign rom_row    = (state == S_FETCH) ? row_lat : row_hold;
    assign rom_col    = (state == S_FETCH) ? cnt     : col_hold;

    assign dx      = pixel_x - x_lat;
    assign hit     = video_on & line_valid & ~fetch_busy & (dx < SPR_W_XY);
    assign lbuf_px = lbuf[dx[COL_BITS-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cnt_d      <= '0;
            col_hold   <= '0;
            row_lat    <= '0;
            row_hold   <= '0;
            x_lat      <= '0;
            line_valid <= 1'b0;
            wr_valid   <= 1'b0;
            pix_rgb    <= 12'h000;
            pix_on     <= 1'b0;
        end else begin
            state    <= state_nx;
            // ROM data lags the address by one cycle, so the write side lags too.
            wr_valid <= (state == S_FETCH);
            cnt_d    <= cnt;

            if (state == S_IDLE && line_start) begin
                x_lat      <= spr_x;
                line_valid <= 1'b0;
                if (start_ok) begin
                    row_lat <= dy[ROW_BITS-1:0];
                    cnt     <= '0;
                end
            end

            if (state == S_FETCH) begin
                cnt      <= cnt + COL_BITS'(1);
                row_hold <= row_lat;
                col_hold <= cnt;
            end

            if (state == S_DRAIN) line_valid <= 1'b1;

            pix_rgb <= hit ? lbuf_px : 12'h000;
            pix_on  <= hit && (lbuf_px != TRANSPARENT);
        end
    end

    // Buffer contents are masked by line_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_valid) lbuf[cnt_d] <= rom_data;
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: vector table, hand-written fetch/reset sequences and
// randomized lines checked against a line-level model of the sprite fetch and display.
module tb_sprite_line_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [9:0]  next_y, spr_x, spr_y, pixel_x;
    logic        video_on;
    logic [0:0]  rom_row, rom_col;
    logic [11:0] rom_data;
    logic        fetch_busy;
    logic [11:0] pix_rgb;
    logic        pix_on;

    logic [11:0] rom [2][2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what the display should show after the last line_start.
    logic [11:0] m_line [2];
    logic        m_valid;
    logic [9:0]  m_x;

    typedef struct {
        logic [9:0]  ny;
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic [9:0]  px;
        logic        von;
        logic        exp_on;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [14];

    sprite_line_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .next_y     (next_y),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .pixel_x    (pixel_x),
        .video_on   (video_on),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_data   (rom_data),
        .fetch_busy (fetch_busy),
        .pix_rgb    (pix_rgb),
        .pix_on     (pix_on)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_row][rom_col];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_line(input logic [9:0] ny, input logic [9:0] sx, input logic [9:0] sy);
        logic [9:0] dy;
        logic       fetch;
        int         cnt;
        dy    = ny - sy;
        fetch = (dy < 10'd2);
        m_x   = sx;
        if (fetch) begin
            m_line[0] = rom[dy[0]][0];
            m_line[1] = rom[dy[0]][1];
        end
        video_on   = 1'b0;
        line_start = 1'b1;
        next_y     = ny;
        spr_x      = sx;
        spr_y      = sy;
        tick();
        line_start = 1'b0;
        cnt = 0;
        while (fetch_busy === 1'b1 && cnt < 10) begin
            cnt++;
            tick();
        end
        check("busy_cycles", cnt, fetch ? 3 : 0);
        m_valid = fetch;
    endtask

    task automatic pix(input logic [9:0] px, input logic von);
        logic [9:0]  dx;
        logic        hit;
        logic [11:0] er;
        dx  = px - m_x;
        hit = von && m_valid && (dx < 10'd2);
        er  = hit ? m_line[dx[0]] : 12'h000;
        pixel_x  = px;
        video_on = von;
        tick();
        check("pix_rgb", pix_rgb, er);
        check("pix_on", pix_on, hit && (er != 12'h000));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; line_start = 1'b0; next_y = '0; spr_x = '0; spr_y = '0;
        pixel_x = '0; video_on = 1'b0; m_valid = 1'b0; m_x = '0;
        m_line[0] = '0; m_line[1] = '0;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) rom[r][c] = 12'hFFF;
        tick(); tick();
        check("rst_busy", fetch_busy, 0);
        check("rst_pix_on", pix_on, 0);
        check("rst_pix_rgb", pix_rgb, 0);
        check("rst_rom_row", rom_row, 0);
        check("rst_rom_col", rom_col, 0);
        reset = 1'b0;
        tick();

        // All-FFF ROM, sprite at (200,100), fetch for y=101: address/busy timing.
        line_start = 1'b1; next_y = 10'd101; spr_x = 10'd200; spr_y = 10'd100;
        tick();
        line_start = 1'b0;
        check("t1_busy0", fetch_busy, 1);
        check("t1_row0", rom_row, 1);
        check("t1_col0", rom_col, 0);
        tick();
        check("t1_busy1", fetch_busy, 1);
        check("t1_row1", rom_row, 1);
        check("t1_col1", rom_col, 1);
        tick();
        check("t1_busy2", fetch_busy, 1);
        tick();
        check("t1_busy3", fetch_busy, 0);
        check("t1_hold_row", rom_row, 1);
        check("t1_hold_col", rom_col, 1);
        m_valid = 1'b1; m_x = 10'd200; m_line[0] = 12'hFFF; m_line[1] = 12'hFFF;
        pix(10'd200, 1'b1);
        pix(10'd201, 1'b1);
        pix(10'd199, 1'b1);
        pix(10'd202, 1'b1);

        // Vector table with a mixed ROM.
        rom[0][0] = 12'h123; rom[0][1] = 12'h000;
        rom[1][0] = 12'hABC; rom[1][1] = 12'hFFF;
        vecs[0]  = '{10'd101,  10'd200,  10'd100, 10'd200,  1'b1, 1'b1, 12'hABC};
        vecs[1]  = '{10'd101,  10'd200,  10'd100, 10'd201,  1'b1, 1'b1, 12'hFFF};
        vecs[2]  = '{10'd101,  10'd200,  10'd100, 10'd199,  1'b1, 1'b0, 12'h000};
        vecs[3]  = '{10'd101,  10'd200,  10'd100, 10'd202,  1'b1, 1'b0, 12'h000};
        vecs[4]  = '{10'd100,  10'd200,  10'd100, 10'd201,  1'b1, 1'b0, 12'h000};
        vecs[5]  = '{10'd100,  10'd200,  10'd100, 10'd200,  1'b1, 1'b1, 12'h123};
        vecs[6]  = '{10'd99,   10'd200,  10'd100, 10'd200,  1'b1, 1'b0, 12'h000};
        vecs[7]  = '{10'd102,  10'd200,  10'd100, 10'd200,  1'b1, 1'b0, 12'h000};
        vecs[8]  = '{10'd101,  10'd200,  10'd100, 10'd200,  1'b0, 1'b0, 12'h000};
        vecs[9]  = '{10'd101,  10'd1023, 10'd100, 10'd1023, 1'b1, 1'b1, 12'hABC};
        vecs[10] = '{10'd101,  10'd1023, 10'd100, 10'd0,    1'b1, 1'b1, 12'hFFF};
        vecs[11] = '{10'd101,  10'd1023, 10'd100, 10'd1,    1'b1, 1'b0, 12'h000};
        vecs[12] = '{10'd0,    10'd5,    10'd1023, 10'd5,   1'b1, 1'b1, 12'hABC};
        vecs[13] = '{10'd1023, 10'd5,    10'd1023, 10'd5,   1'b1, 1'b1, 12'h123};
        for (int i = 0; i < 14; i++) begin
            start_line(vecs[i].ny, vecs[i].sx, vecs[i].sy);
            pixel_x  = vecs[i].px;
            video_on = vecs[i].von;
            tick();
            check($sformatf("vec%0d_rgb", i), pix_rgb, vecs[i].exp_rgb);
            check($sformatf("vec%0d_on", i), pix_on, vecs[i].exp_on);
        end

        // Second line_start during FETCH is ignored; first row is kept.
        line_start = 1'b1; next_y = 10'd101; spr_x = 10'd200; spr_y = 10'd100;
        tick();
        line_start = 1'b1; next_y = 10'd100; spr_x = 10'd50;
        tick();
        line_start = 1'b0;
        begin
            int cnt;
            cnt = 1;
            while (fetch_busy === 1'b1 && cnt < 10) begin
                cnt++;
                tick();
            end
            check("t4_busy_cycles", cnt, 3);
        end
        m_valid = 1'b1; m_x = 10'd200; m_line[0] = 12'hABC; m_line[1] = 12'hFFF;
        pix(10'd200, 1'b1);
        pix(10'd50, 1'b1);
        pix(10'd201, 1'b0);

        // Reset mid-fetch: outputs clear at once, line blank until next fetch.
        pixel_x = 10'd200; video_on = 1'b1;
        line_start = 1'b1; next_y = 10'd101;
        tick();
        line_start = 1'b0;
        check("t5_pre_on", pix_on, 1);
        check("t5_pre_busy", fetch_busy, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", fetch_busy, 0);
        check("t5_rst_on", pix_on, 0);
        tick();
        reset = 1'b0;
        m_valid = 1'b0;
        tick();
        pix(10'd200, 1'b1);
        pix(10'd201, 1'b1);
        start_line(10'd101, 10'd200, 10'd100);
        pix(10'd200, 1'b1);
        pix(10'd201, 1'b1);

        // Randomized lines against the model.
        for (int it = 0; it < 150; it++) begin
            logic [9:0] sx, sy, ny;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    rom[r][c] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            sx = ($urandom_range(0, 3) == 0) ? 10'(1022 + $urandom_range(0, 1)) : 10'($urandom);
            sy = 10'($urandom);
            ny = sy + 10'($urandom_range(0, 4)) - 10'd1;
            start_line(ny, sx, sy);
            for (int k = 0; k < 5; k++)
                pix(sx + 10'($urandom_range(0, 4)) - 10'd1, ($urandom_range(0, 4) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
